// File: rtl/job_mgr_pkg.sv
// Shared types and constants for the job dispatch manager and its address bank.
package job_mgr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    POLL,
    DISPATCH,
    GRANT,
    DRAIN,
    DONE
  } job_state_t;

  localparam int DESC_VALID_BIT      = 0;
  localparam int DESC_LAST_BIT       = 1;
  localparam int DEFAULT_DESC_STRIDE = 64;

endpackage

// File: rtl/job_addr_bank.sv
// Per-kernel descriptor address registers; a grant vector picks the slot to load.
module job_addr_bank
  import job_mgr_pkg::*;
#(
  parameter int KERNEL_NUM = 8,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [KERNEL_NUM-1:0]            grant,
  input  logic [ADDR_WIDTH-1:0]            addr,
  output logic [KERNEL_NUM*ADDR_WIDTH-1:0] job_addr,
  output logic [KERNEL_NUM-1:0]            job_load
);

  logic [KERNEL_NUM-1:0] grant_sel;

  // A multi-bit grant is illegal upstream; isolating the lowest set bit keeps
  // the bank from ever writing two slots with the same descriptor.
  assign grant_sel = grant & (~grant + KERNEL_NUM'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_addr <= '0;
      job_load <= '0;
    end else begin
      job_load <= load ? grant_sel : '0;
      if (load) begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
          if (grant_sel[k]) begin
            job_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <= addr;
          end
        end
      end
    end
  end

endmodule

// File: rtl/job_dispatch_manager.sv
// Walks the host descriptor ring and hands each valid descriptor to a granted kernel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a manager_start rising edge
// FETCH     | header read request held until rd_ack
// WAIT_DATA | waiting for header data (discarded when aborting)
// POLL      | descriptor not yet valid, back-off before re-reading
// DISPATCH  | waiting for a free kernel, then job_start
// GRANT     | watching kernel_start for the one-hot grant
// DRAIN     | waiting for all kernels idle, then run_done
// DONE      | run finished, waiting for manager_start to drop
module job_dispatch_manager
  import job_mgr_pkg::*;
#(
  parameter int KERNEL_NUM    = 8,
  parameter int ADDR_WIDTH    = 64,
  parameter int DESC_STRIDE   = DEFAULT_DESC_STRIDE,
  parameter int POLL_CYCLES   = 256,
  parameter int GRANT_TIMEOUT = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             manager_start,
  input  logic [ADDR_WIDTH-1:0]            init_addr,
  input  logic                             new_job,
  input  logic                             job_done,
  output logic                             job_start,
  input  logic [KERNEL_NUM-1:0]            kernel_start,
  output logic                             rd_req,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic                             rd_ack,
  input  logic                             rd_valid,
  input  logic [63:0]                      rd_data,
  output logic [KERNEL_NUM*ADDR_WIDTH-1:0] kernel_job_addr,
  output logic [KERNEL_NUM-1:0]            kernel_job_load,
  output logic                             busy,
  output logic                             run_done,
  output logic [31:0]                      jobs_dispatched
);

  localparam int POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int GRANT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

  job_state_t            state_q, state_d;
  logic                  start_q;
  logic                  start_rise;
  logic                  abort_q;
  logic                  aborting;
  logic                  hdr_last;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [POLL_W-1:0]     poll_cnt;
  logic [GRANT_W-1:0]    grant_cnt;
  logic [31:0]           jobs_q;
  logic                  grant_hit;
  logic                  grant_load;
  logic                  hdr_is_valid;
  logic                  rd_data_unused;

  assign start_rise     = manager_start & ~start_q;
  assign aborting       = abort_q | ~manager_start;
  assign grant_hit      = |kernel_start;
  assign hdr_is_valid   = rd_data[DESC_VALID_BIT];
  assign rd_data_unused = ^rd_data;

  assign busy            = (state_q != IDLE);
  assign rd_addr         = cur_addr;
  assign jobs_dispatched = jobs_q;

  always_comb begin
    state_d    = state_q;
    rd_req     = 1'b0;
    job_start  = 1'b0;
    run_done   = 1'b0;
    grant_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = FETCH;
      end
      FETCH: begin
        // An abort never drops a request in flight; the read is completed first.
        rd_req = 1'b1;
        if (rd_ack) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rd_valid) begin
          if (aborting)          state_d = DRAIN;
          else if (hdr_is_valid) state_d = DISPATCH;
          else                   state_d = POLL;
        end
      end
      POLL: begin
        if (!manager_start)      state_d = DRAIN;
        else if (poll_cnt == '0) state_d = FETCH;
      end
      DISPATCH: begin
        if (!manager_start) begin
          state_d = DRAIN;
        end else if (new_job) begin
          job_start = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (grant_hit) begin
          grant_load = 1'b1;
          state_d    = (hdr_last || aborting) ? DRAIN : FETCH;
        end else if (grant_cnt == '0) begin
          state_d = aborting ? DRAIN : DISPATCH;
        end
      end
      DRAIN: begin
        if (job_done) begin
          run_done = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!manager_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // start_q resets high so a start bit already set at reset is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;
      abort_q   <= 1'b0;
      hdr_last  <= 1'b0;
      cur_addr  <= '0;
      poll_cnt  <= '0;
      grant_cnt <= '0;
      jobs_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= manager_start;

      if (state_q == IDLE && start_rise) begin
        cur_addr <= init_addr;
        jobs_q   <= '0;
        abort_q  <= 1'b0;
      end

      if ((state_q == FETCH || state_q == WAIT_DATA) && !manager_start) begin
        abort_q <= 1'b1;
      end

      if (state_q == WAIT_DATA && rd_valid) begin
        hdr_last <= rd_data[DESC_LAST_BIT];
        poll_cnt <= POLL_W'(POLL_CYCLES - 1);
      end else if (state_q == POLL && poll_cnt != '0) begin
        poll_cnt <= poll_cnt - 1'b1;
      end

      if (job_start) begin
        grant_cnt <= GRANT_W'(GRANT_TIMEOUT - 1);
      end else if (state_q == GRANT && grant_cnt != '0) begin
        grant_cnt <= grant_cnt - 1'b1;
      end

      if (grant_load) begin
        jobs_q   <= jobs_q + 32'd1;
        cur_addr <= cur_addr + ADDR_WIDTH'(DESC_STRIDE);
      end
    end
  end

  job_addr_bank #(
    .KERNEL_NUM (KERNEL_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_load),
    .grant    (kernel_start),
    .addr     (cur_addr),
    .job_addr (kernel_job_addr),
    .job_load (kernel_job_load)
  );

endmodule

// File: tb/tb_job_dispatch_manager.sv
// Scoreboard bench for job_dispatch_manager: directed runs with hand-computed expectations.
module tb_job_dispatch_manager;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         manager_start;
  logic [63:0]  init_addr;
  logic         new_job;
  logic         job_done;
  logic         job_start;
  logic [7:0]   kernel_start;
  logic         rd_req;
  logic [63:0]  rd_addr;
  logic         rd_ack;
  logic         rd_valid;
  logic [63:0]  rd_data;
  logic [511:0] kernel_job_addr;
  logic [7:0]   kernel_job_load;
  logic         busy;
  logic         run_done;
  logic [31:0]  jobs_dispatched;

  typedef struct {
    logic [7:0]  vec;
    logic [63:0] addr;
    logic [31:0] cnt;
  } load_t;

  logic [63:0] hdr_q[$];
  logic [63:0] exp_rd_q[$];
  logic [7:0]  grant_q[$];
  load_t       exp_load_q[$];
  logic [31:0] exp_done_q[$];
  int          rd_times[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int js_count = 0;
  int rdreq_cycles = 0;
  int ack_delay = 0;

  job_dispatch_manager dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .manager_start   (manager_start),
    .init_addr       (init_addr),
    .new_job         (new_job),
    .job_done        (job_done),
    .job_start       (job_start),
    .kernel_start    (kernel_start),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ack          (rd_ack),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .kernel_job_addr (kernel_job_addr),
    .kernel_job_load (kernel_job_load),
    .busy            (busy),
    .run_done        (run_done),
    .jobs_dispatched (jobs_dispatched)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an observable event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (job_start) js_count++;
      if (rd_req) rdreq_cycles++;
      if (rd_req && rd_ack) begin
        rd_times.push_back(cyc);
        if (exp_rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_read: got addr 0x%0h, expected no read", rd_addr);
        end else check("rd_addr", rd_addr, exp_rd_q.pop_front());
      end
      if (kernel_job_load != 8'h00) begin
        if (exp_load_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_load: got 0x%0h, expected no load", kernel_job_load);
        end else begin
          load_t e;
          int k;
          e = exp_load_q.pop_front();
          k = onehot_idx(e.vec);
          check("load_vec", {56'h0, kernel_job_load}, {56'h0, e.vec});
          check("slot_addr", kernel_job_addr[k*64 +: 64], e.addr);
          check("jobs_at_load", {32'h0, jobs_dispatched}, {32'h0, e.cnt});
        end
      end
      if (run_done) begin
        if (exp_done_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_run_done: got pulse, expected none");
        end else check("run_done_jobs", {32'h0, jobs_dispatched}, {32'h0, exp_done_q.pop_front()});
      end
    end
  end

  // Host memory: ack after ack_delay cycles, header data the cycle after the ack.
  initial begin
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 64'h0;
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      if (rd_req && rst_n) begin
        for (int i = 0; i < ack_delay; i++) begin @(posedge clk); #1; end
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        rd_valid = 1'b1;
        rd_data = (hdr_q.size() != 0) ? hdr_q.pop_front() : 64'h0;
      end
    end
  end

  // Global slave grant: one cycle after job_start; a queued 0 means no grant.
  initial begin
    logic [7:0] g;
    kernel_start = 8'h00;
    forever begin
      @(negedge clk);
      if (job_start && rst_n) begin
        g = (grant_q.size() != 0) ? grant_q.pop_front() : 8'h00;
        @(posedge clk); #1 kernel_start = g;
        @(posedge clk); #1 kernel_start = 8'h00;
      end
    end
  end

  task automatic wait_queues(input string name, input int budget, input bit with_done);
    int n = 0;
    while ((exp_rd_q.size() != 0 || exp_load_q.size() != 0 ||
            (with_done && exp_done_q.size() != 0)) && n < budget) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d reads/%0d loads/%0d dones pending, expected none",
               name, exp_rd_q.size(), exp_load_q.size(), exp_done_q.size());
      exp_rd_q.delete(); exp_load_q.delete(); exp_done_q.delete();
    end
  endtask

  task automatic start_run(input logic [63:0] a);
    init_addr = a;
    @(negedge clk);
    manager_start = 1'b1;
  endtask

  task automatic end_run();
    manager_start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_run", {63'h0, busy}, 64'h0);
  endtask

  task automatic push_load(input logic [7:0] v, input logic [63:0] a, input logic [31:0] c);
    load_t e;
    e.vec = v; e.addr = a; e.cnt = c;
    exp_load_q.push_back(e);
  endtask

  initial begin
    int js0, rq0, n;
    rst_n = 1'b0; manager_start = 1'b1; init_addr = 64'h0; new_job = 1'b1; job_done = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_rd_req", {63'h0, rd_req}, 64'h0);
    check("rst_job_start", {63'h0, job_start}, 64'h0);
    check("rst_slots_zero", {63'h0, (kernel_job_addr != 512'h0)}, 64'h0);
    check("rst_jobs", {32'h0, jobs_dispatched}, 64'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held_start_no_run", {63'h0, busy}, 64'h0);
    manager_start = 1'b0;
    repeat (2) @(negedge clk);

    // Three-job run; run_done must wait for job_done
    job_done = 1'b0; js0 = js_count;
    hdr_q = '{64'h1, 64'hABCD_0000_0000_0001, 64'h3};
    grant_q = '{8'h80, 8'h40, 8'h20};
    exp_rd_q = '{64'h1000, 64'h1040, 64'h1080};
    push_load(8'h80, 64'h1000, 1); push_load(8'h40, 64'h1040, 2); push_load(8'h20, 64'h1080, 3);
    start_run(64'h1000);
    wait_queues("t1_jobs", 400, 1'b0);
    repeat (10) @(negedge clk);
    check("t1_busy_drain", {63'h0, busy}, 64'h1);
    check("t1_jobs", {32'h0, jobs_dispatched}, 64'd3);
    exp_done_q.push_back(32'd3);
    job_done = 1'b1;
    wait_queues("t1_done", 50, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_done_holds", {63'h0, busy}, 64'h1);
    check("t1_job_starts", js_count - js0, 64'd3);
    end_run();

    // Invalid descriptor polling
    rd_times.delete();
    hdr_q = '{64'h0, 64'h0, 64'h3};
    grant_q = '{8'h01};
    exp_rd_q = '{64'h2000, 64'h2000, 64'h2000};
    push_load(8'h01, 64'h2000, 1);
    exp_done_q.push_back(32'd1);
    start_run(64'h2000);
    wait_queues("t2", 1500, 1'b1);
    check("t2_read_count", rd_times.size(), 64'd3);
    if (rd_times.size() == 3) begin
      check("t2_gap1", rd_times[1] - rd_times[0], 64'd258);
      check("t2_gap2", rd_times[2] - rd_times[0], 64'd516);
    end
    end_run();

    // Backpressure on new_job
    new_job = 1'b0;
    hdr_q = '{64'h3}; grant_q = '{8'h04}; exp_rd_q = '{64'h3000};
    push_load(8'h04, 64'h3000, 1);
    exp_done_q.push_back(32'd1);
    start_run(64'h3000);
    repeat (6) @(negedge clk);
    js0 = js_count; rq0 = rdreq_cycles;
    repeat (50) @(negedge clk);
    check("t3_no_job_start", js_count - js0, 64'd0);
    check("t3_no_rd_req", rdreq_cycles - rq0, 64'd0);
    check("t3_busy", {63'h0, busy}, 64'h1);
    new_job = 1'b1;
    wait_queues("t3", 50, 1'b1);
    end_run();

    // Grant timeout then re-dispatch of the same descriptor
    js0 = js_count;
    hdr_q = '{64'h3}; grant_q = '{8'h00, 8'h10}; exp_rd_q = '{64'h4000};
    push_load(8'h10, 64'h4000, 1);
    exp_done_q.push_back(32'd1);
    start_run(64'h4000);
    wait_queues("t4", 100, 1'b1);
    check("t4_job_starts", js_count - js0, 64'd2);
    end_run();

    // Abort while a read is pending
    job_done = 1'b0; ack_delay = 5; js0 = js_count;
    hdr_q = '{64'h1}; exp_rd_q = '{64'h5000};
    start_run(64'h5000);
    n = 0;
    while (!rd_req && n < 10) begin @(negedge clk); n++; end
    check("t5_rd_req_seen", {63'h0, rd_req}, 64'h1);
    manager_start = 1'b0;
    wait_queues("t5_read", 30, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_data_consumed", hdr_q.size(), 64'd0);
    check("t5_no_job_start", js_count - js0, 64'd0);
    check("t5_draining", {63'h0, busy}, 64'h1);
    exp_done_q.push_back(32'd0);
    job_done = 1'b1;
    wait_queues("t5_done", 20, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_idle", {63'h0, busy}, 64'h0);
    ack_delay = 0;

    // Address wrap; multi-bit grant takes the lowest bit
    hdr_q = '{64'h1, 64'h3}; grant_q = '{8'h02, 8'h0C};
    exp_rd_q = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
    push_load(8'h02, 64'hFFFF_FFFF_FFFF_FFC0, 1); push_load(8'h04, 64'h0, 2);
    exp_done_q.push_back(32'd2);
    start_run(64'hFFFF_FFFF_FFFF_FFC0);
    wait_queues("t6", 100, 1'b1);
    check("t6_slot7_kept", kernel_job_addr[7*64 +: 64], 64'h1000);
    check("t6_slot4_kept", kernel_job_addr[4*64 +: 64], 64'h4000);
    check("t6_slot3_untouched", kernel_job_addr[3*64 +: 64], 64'h0);
    end_run();

    // Asynchronous reset in GRANT
    hdr_q = '{64'h1}; grant_q = '{8'h00}; exp_rd_q = '{64'h6000};
    js0 = js_count;
    start_run(64'h6000);
    n = 0;
    while (js_count == js0 && n < 20) begin @(negedge clk); n++; end
    check("t7_job_start_seen", js_count - js0, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", {63'h0, busy}, 64'h0);
    check("t7_rst_rd_addr", rd_addr, 64'h0);
    check("t7_rst_slots", {63'h0, (kernel_job_addr != 512'h0)}, 64'h0);
    check("t7_rst_outs", {58'h0, job_start, rd_req, run_done, (kernel_job_load != 8'h0),
                          (jobs_dispatched != 32'h0), 1'b0}, 64'h0);
    hdr_q.delete(); grant_q.delete(); exp_rd_q.delete(); exp_load_q.delete(); exp_done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t7_no_restart", {63'h0, busy}, 64'h0);
    manager_start = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
